// File: rtl/fft_out_unloader.sv
// Captures a frame of 8 parallel FFT result words in one cycle and streams it
// out one word per cycle, in bit-reversed or natural index order.
module fft_out_unloader #(
  parameter int WIDTH  = 16,
  parameter int BITREV = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [8*WIDTH-1:0] data_in,
  output logic [WIDTH-1:0]   out_data,
  output logic [2:0]         out_index,
  output logic               out_valid,
  input  logic               out_ready,
  output logic               out_last,
  output logic               busy
);

  // Handshakes: a transfer happens on a rising edge where valid && ready are
  // both high; valid never depends on ready, and a stalled word holds steady.

  typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

  state_t           state_q, state_d;
  logic [2:0]       cnt_q, cnt_d;
  logic [WIDTH-1:0] bank_q [8];
  logic             rdy_q;
  logic             load_fire;
  logic             out_fire;
  logic [2:0]       idx;

  // rdy_q keeps load_ready low during reset and for the first edge after it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= '0;
    end else if (load_fire) begin
      for (int i = 0; i < 8; i++) bank_q[i] <= data_in[WIDTH*i +: WIDTH];
    end
  end

  assign idx = (BITREV != 0) ? {cnt_q[0], cnt_q[1], cnt_q[2]} : cnt_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    busy       = (state_q == STREAM);
    out_valid  = busy;
    out_last   = busy && (cnt_q == 3'd7);
    out_index  = busy ? idx : 3'd0;
    out_data   = busy ? bank_q[idx] : '0;
    // A new frame may land on the same edge the final word leaves.
    load_ready = rdy_q && ((state_q == IDLE) || ((cnt_q == 3'd7) && out_ready));
    load_fire  = load_valid && load_ready;
    out_fire   = out_valid && out_ready;

    if (out_fire) begin
      cnt_d = cnt_q + 3'd1;
      if (cnt_q == 3'd7) state_d = IDLE;
    end
    if (load_fire) begin
      cnt_d   = 3'd0;
      state_d = STREAM;
    end
  end

endmodule

// File: tb/tb_fft_out_unloader.sv
// Directed bench for fft_out_unloader: one instance in bit-reversed order, one
// in natural order, each with its own expected-word queue.
module tb_fft_out_unloader;

  localparam int W = 16;

  logic           clk;
  logic           reset;

  logic           lv1, lr1, ov1, or1, ol1, bz1;
  logic [8*W-1:0] din1;
  logic [W-1:0]   od1;
  logic [2:0]     oi1;

  logic           lv0, lr0, ov0, or0, ol0, bz0;
  logic [8*W-1:0] din0;
  logic [W-1:0]   od0;
  logic [2:0]     oi0;

  int checks = 0;
  int errors = 0;

  // Entries are {last, index, data}.
  logic [W+3:0] exp1_q[$];
  logic [W+3:0] exp0_q[$];

  fft_out_unloader #(.WIDTH(W), .BITREV(1)) dut_rev (
    .clk(clk), .reset(reset), .load_valid(lv1), .load_ready(lr1), .data_in(din1),
    .out_data(od1), .out_index(oi1), .out_valid(ov1), .out_ready(or1),
    .out_last(ol1), .busy(bz1)
  );

  fft_out_unloader #(.WIDTH(W), .BITREV(0)) dut_nat (
    .clk(clk), .reset(reset), .load_valid(lv0), .load_ready(lr0), .data_in(din0),
    .out_data(od0), .out_index(oi0), .out_valid(ov0), .out_ready(or0),
    .out_last(ol0), .busy(bz0)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [2:0] rev_pos(input int i);
    case (i)
      0: return 3'd0;
      1: return 3'd4;
      2: return 3'd2;
      3: return 3'd6;
      4: return 3'd1;
      5: return 3'd5;
      6: return 3'd3;
      default: return 3'd7;
    endcase
  endfunction

  function automatic logic [8*W-1:0] ramp(input logic [W-1:0] base);
    logic [8*W-1:0] f;
    for (int i = 0; i < 8; i++) f[W*i +: W] = base + W'(i);
    return f;
  endfunction

  task automatic push_rev(input logic [8*W-1:0] f);
    logic [2:0] ix;
    for (int i = 0; i < 8; i++) begin
      ix = rev_pos(i);
      exp1_q.push_back({(i == 7), ix, f[W*ix +: W]});
    end
  endtask

  task automatic push_nat(input logic [8*W-1:0] f);
    for (int i = 0; i < 8; i++)
      exp0_q.push_back({(i == 7), 3'(i), f[W*i +: W]});
  endtask

  // Drives one frame into the bit-reversed instance; called just after an edge.
  task automatic load_rev(input logic [8*W-1:0] f);
    din1 = f;
    lv1  = 1'b1;
    push_rev(f);
    step();
    lv1  = 1'b0;
    check("load_latency_valid", 32'(ov1), 32'd1);
    check("load_first_index", 32'(oi1), 32'd0);
  endtask

  task automatic drain_rev(input int budget);
    int n;
    n = 0;
    while (exp1_q.size() != 0 && n < budget) begin
      step();
      n++;
    end
    check("drain_rev_left", 32'(exp1_q.size()), 32'd0);
  endtask

  // Scoreboard monitors: sample mid-cycle, pop on each transfer.
  always @(negedge clk) begin
    if (!reset && ov1 && or1) begin
      checks++;
      assert (exp1_q.size() != 0) else begin
        errors++;
        $error("FAIL rev_unexpected_word observed=%h expected=none", {ol1, oi1, od1});
      end
      if (exp1_q.size() != 0) check("rev_word", 32'({ol1, oi1, od1}), 32'(exp1_q.pop_front()));
    end
  end

  always @(negedge clk) begin
    if (!reset && ov0 && or0) begin
      checks++;
      assert (exp0_q.size() != 0) else begin
        errors++;
        $error("FAIL nat_unexpected_word observed=%h expected=none", {ol0, oi0, od0});
      end
      if (exp0_q.size() != 0) check("nat_word", 32'({ol0, oi0, od0}), 32'(exp0_q.pop_front()));
    end
  end

  initial begin
    logic [8*W-1:0] nat_f;
    logic [8*W-1:0] f2;
    int n;

    // 1: reset with load_valid high
    reset = 1'b1;
    lv1 = 1'b1; din1 = ramp(16'h0900); or1 = 1'b1;
    lv0 = 1'b0; din0 = '0;             or0 = 1'b1;
    #2;
    check("rst_out_valid", 32'(ov1), 32'd0);
    check("rst_busy", 32'(bz1), 32'd0);
    check("rst_load_ready", 32'(lr1), 32'd0);
    check("rst_out_data", 32'(od1), 32'd0);
    check("rst_out_index", 32'(oi1), 32'd0);
    check("rst_out_last", 32'(ol1), 32'd0);
    step();
    step();
    reset = 1'b0;
    #1;
    check("post_rel_load_ready", 32'(lr1), 32'd0);
    step();
    check("first_edge_load_ready", 32'(lr1), 32'd1);
    check("first_edge_no_capture", 32'(bz1), 32'd0);
    check("first_edge_no_valid", 32'(ov1), 32'd0);
    lv1 = 1'b0;
    step();

    // 2: bit-reversed order, consumer always ready
    or1 = 1'b1;
    load_rev(ramp(16'h0100));
    drain_rev(20);
    check("t2_idle_busy", 32'(bz1), 32'd0);
    check("t2_idle_valid", 32'(ov1), 32'd0);

    // 3: stalls with ready pattern 1,0,0,1
    load_rev(ramp(16'h0100));
    n = 0;
    while (exp1_q.size() != 0 && n < 40) begin
      or1 = ((n % 4) == 0) || ((n % 4) == 3);
      if (!or1) check("t3_stall_hold", 32'(od1), 32'(exp1_q[0][W-1:0]));
      step();
      n++;
    end
    check("t3_drain_left", 32'(exp1_q.size()), 32'd0);
    check("t3_idle_busy", 32'(bz1), 32'd0);
    or1 = 1'b1;
    step();

    // 4: back-to-back frames, second offered throughout the first
    f2 = ramp(16'hA000);
    load_rev(ramp(16'h0100));
    din1 = f2;
    lv1  = 1'b1;
    for (int c = 0; c < 16; c++) begin
      check("t4_no_gap", 32'(ov1), 32'd1);
      check("t4_load_ready", 32'(lr1), 32'((c % 8) == 7));
      if (c == 7) push_rev(f2);
      step();
      if (c == 7) lv1 = 1'b0;
    end
    check("t4_drain_left", 32'(exp1_q.size()), 32'd0);
    check("t4_idle_busy", 32'(bz1), 32'd0);

    // 5: natural order, edge-value words
    nat_f = {16'h5555, 16'hFEDC, 16'h1234, 16'h0000, 16'h0001, 16'h7FFF, 16'h8000, 16'hFFFF};
    din0 = nat_f;
    lv0  = 1'b1;
    push_nat(nat_f);
    step();
    lv0  = 1'b0;
    check("t5_latency_valid", 32'(ov0), 32'd1);
    n = 0;
    while (exp0_q.size() != 0 && n < 20) begin
      step();
      n++;
    end
    check("t5_drain_left", 32'(exp0_q.size()), 32'd0);
    check("t5_idle_busy", 32'(bz0), 32'd0);

    // 6: asynchronous reset after the third transfer
    load_rev(ramp(16'h0200));
    step();
    step();
    step();
    check("t6_three_sent", 32'(exp1_q.size()), 32'd5);
    #2;
    reset = 1'b1;
    #1;
    check("t6_rst_valid", 32'(ov1), 32'd0);
    check("t6_rst_busy", 32'(bz1), 32'd0);
    check("t6_rst_data", 32'(od1), 32'd0);
    exp1_q.delete();
    step();
    #2;
    reset = 1'b0;
    step();
    check("t6_rel_load_ready", 32'(lr1), 32'd1);
    check("t6_rel_busy", 32'(bz1), 32'd0);
    for (int c = 0; c < 3; c++) begin
      check("t6_no_leftover", 32'(ov1), 32'd0);
      step();
    end
    load_rev(ramp(16'h0300));
    drain_rev(20);
    check("t6_final_busy", 32'(bz1), 32'd0);

    // Final report
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_out_unloader.md
Name: fft_out_unloader

Overview:
- Read-side counterpart to the FFT's parallel result registers.
- Captures one frame of 8 parallel 16-bit FFT results in a single cycle.
- Streams the frame out one word per cycle over a valid/ready handshake, in bit-reversed or natural index order.
- Sits between the last butterfly stage's output registers and the downstream serial consumer.

Parameters:
- WIDTH, 16, bits per sample word.
- BITREV, 1. 1 = emit in bit-reversed index order (0,4,2,6,1,5,3,7); 0 = natural order 0..7.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_valid  input  1  a frame is present on data_in.
- load_ready  output  1  block can accept a frame this cycle.
- data_in  input  8*WIDTH  frame; word i = data_in[WIDTH*i +: WIDTH].
- out_data  output  WIDTH  current output word.
- out_index  output  3  frequency index of out_data.
- out_valid  output  1  out_data/out_index are valid.
- out_ready  input  1  consumer accepts the word this cycle.
- out_last  output  1  the current word is the 8th of the frame.
- busy  output  1  a frame is held (state STREAM).

Behaviour:
- Clock and reset: one clock, clk. reset is asynchronous, active-high. While reset is asserted:
  - state=IDLE, sequence counter cnt=0, all 8 bank words=0.
  - out_valid=0, out_last=0, busy=0, out_index=0, out_data=0.
  - load_ready=0.
- After reset deasserts, load_ready=1 from the first clock edge.
- States: IDLE, STREAM.
- IDLE:
  - load_ready=1, out_valid=0.
  - On load_valid&&load_ready at edge k: all 8 words are written into the bank, cnt<=0, state<=STREAM.
  - out_valid=1 in cycle k+1. Load-to-first-word latency is 1 cycle.
- STREAM:
  - out_valid=1, busy=1.
  - out_index = BITREV ? bitreverse(cnt) : cnt; out_data = bank[out_index]. This is a combinational mux from registered state, so it is stable while stalled.
  - out_last = (cnt==7).
- Transfer: out_valid&&out_ready at an edge. Each transfer sets cnt<=cnt+1. With out_ready=0, cnt, out_data and out_index hold indefinitely (stall).
- Final transfer (cnt==7 with transfer): cnt wraps to 0.
  - If load_valid is also high in that cycle, load_ready=1 (combinational: IDLE or (STREAM&&cnt==7&&out_ready)). The new frame is captured, state stays STREAM, and the next cycle presents word 0 of the new frame with no bubble.
  - Otherwise state<=IDLE.
- load_valid in STREAM before the final transfer: load_ready=0, the frame is ignored, and the bank is unchanged.
- Bank contents persist after a frame drains; they are overwritten only by an accepted load.
- No arithmetic is performed. Words pass through bit-exact.
- Reset asserted mid-frame: output state clears immediately (asynchronous). The partial frame is lost and no further words are emitted.

Test Plan:
1. Reset asserted with load_valid=1, then released -> during reset out_valid=0, busy=0, load_ready=0, out_data=0. On the first edge after release load_ready=1 and no frame is captured.
2. BITREV=1; load word i = 0x0100+i; out_ready=1 continuously -> out_valid rises the cycle after the load. Outputs are 0x0100,0x0104,0x0102,0x0106,0x0101,0x0105,0x0103,0x0107 with out_index 0,4,2,6,1,5,3,7. out_last=1 only on 0x0107, then IDLE.
3. Same frame, out_ready toggling 1,0,0,1,... -> out_data holds during stalls. Exactly 8 transfers in the same order, with no duplicates or drops.
4. Back-to-back: second frame word i = 0xA000+i, load_valid held high through the first frame -> the second frame is accepted only on the first frame's final-transfer cycle. 0xA000 appears the very next cycle, giving 16 consecutive transfers with no gap.
5. BITREV=0; frame words 0xFFFF,0x8000,0x7FFF,0x0001,0,0x1234,0xFEDC,0x5555 -> emitted in that exact order with out_index 0..7 and bit-exact values.
6. Assert reset asynchronously (between edges) after the 3rd transfer -> out_valid drops immediately. After release, busy=0 and load_ready=1. The remaining 5 words are never emitted, and a new load streams correctly from index 0.
